// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
// The echo path is built only when UART_TX_ARB_ECHO_EN is defined.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_e;

  localparam int unsigned NREQ       = 4;
  localparam int unsigned REQ_IDX_W  = 2;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ECHO_DEPTH = 4;
  localparam int unsigned ECHO_PTR_W = 2;
  localparam int unsigned LEVEL_W    = 3;
  localparam int unsigned CNT_W      = 16;

  // Round-robin pick: returns {found, index}, searching from last+1 upward.
  function automatic logic [REQ_IDX_W:0] rr_pick(input logic [NREQ-1:0]      req,
                                                 input logic [REQ_IDX_W-1:0] last);
    logic [REQ_IDX_W-1:0] idx;
    logic [REQ_IDX_W:0]   res;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = last + REQ_IDX_W'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// 4x8 FIFO holding received bytes waiting to be echoed; drops and flags
// bytes that arrive while full unless a pop frees a slot in the same cycle.
module uart_echo_fifo
  import uart_arb_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               push,
  input  logic [BYTE_W-1:0]  push_data,
  input  logic               pop,
  output logic [BYTE_W-1:0]  pop_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level,
  output logic               ovf
);

  logic [BYTE_W-1:0]     mem_q [ECHO_DEPTH];
  logic [ECHO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ECHO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]    level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  do_push, do_pop;

  assign full     = (level_q == LEVEL_W'(ECHO_DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + ECHO_PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + ECHO_PTR_W'(do_pop);
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q | (push && full && !pop);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants one byte per transmit slot to uart_hs: echo bytes first, then
// round-robin over four requesters. Echo path enabled by UART_TX_ARB_ECHO_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned BYTE_CYCLES = 4340
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BYTE_W-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  input  logic                     rx_valid,
  input  logic [BYTE_W-1:0]        rx_data,
  output logic                     uart_send,
  output logic [BYTE_W-1:0]        uart_data,
  output logic                     busy,
  output logic [LEVEL_W-1:0]       echo_level,
  output logic                     echo_ovf
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BYTE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REQ_IDX_W-1:0] last_q, last_d;
  logic                 send_q, send_d;
  logic [BYTE_W-1:0]    data_q, data_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic [REQ_IDX_W:0]   pick;
  logic                 echo_avail;
  logic [BYTE_W-1:0]    echo_byte;

`ifdef UART_TX_ARB_ECHO_EN
  logic echo_empty;
  logic echo_pop;
  logic unused_full;

  assign echo_pop   = (state_q == IDLE) && echo_avail;
  assign echo_avail = !echo_empty;

  uart_echo_fifo u_echo_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (echo_pop),
    .pop_data  (echo_byte),
    .full      (unused_full),
    .empty     (echo_empty),
    .level     (echo_level),
    .ovf       (echo_ovf)
  );
`else
  logic unused_rx;

  assign unused_rx  = ^{rx_valid, rx_data};
  assign echo_avail = 1'b0;
  assign echo_byte  = '0;
  assign echo_level = '0;
  assign echo_ovf   = 1'b0;
`endif

  assign pick = rr_pick(req, last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    send_d  = 1'b0;
    data_d  = data_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (echo_avail) begin
          send_d  = 1'b1;
          data_d  = echo_byte;
          cnt_d   = RELOAD;
          state_d = GAP;
        end else if (pick[REQ_IDX_W]) begin
          send_d  = 1'b1;
          data_d  = req_data[BYTE_W*pick[REQ_IDX_W-1:0] +: BYTE_W];
          ack_d   = NREQ'(1) << pick[REQ_IDX_W-1:0];
          last_d  = pick[REQ_IDX_W-1:0];
          cnt_d   = RELOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == GAP);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= REQ_IDX_W'(NREQ - 1);
      send_q  <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      send_q  <= send_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_send = send_q;
  assign uart_data = data_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; echo tests run when
// UART_TX_ARB_ECHO_EN is defined, the echo-disabled test otherwise.
module tb_uart_tx_arbiter;

  localparam int unsigned BC = 10;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        uart_send;
  logic [7:0]  uart_data;
  logic        busy;
  logic [2:0]  echo_level;
  logic        echo_ovf;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          t0;
  int          send_cyc[$];
  logic [11:0] exp_q[$];
  logic [11:0] m_exp;

  uart_tx_arbiter #(.BYTE_CYCLES(BC)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .uart_send  (uart_send),
    .uart_data  (uart_data),
    .busy       (busy),
    .echo_level (echo_level),
    .echo_ovf   (echo_ovf)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: every send is matched against the next expected {ack, byte}.
  always @(negedge sys_clk) begin
    if (sys_rst_n && uart_send) begin
      send_cyc.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_send: got ack=%b data=%h, required no send", ack, uart_data);
      end else begin
        m_exp = exp_q.pop_front();
        if ({ack, uart_data} !== m_exp) begin
          fails++;
          $display("FAIL send_payload: got ack=%b data=%h, required ack=%b data=%h",
                   ack, uart_data, m_exp[11:8], m_exp[7:0]);
        end
      end
    end else if (sys_rst_n && ack !== 4'b0000) begin
      tests++;
      fails++;
      $display("FAIL ack_without_send: got ack=%b, required 0000", ack);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req       = '0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    repeat (3) @(negedge sys_clk);
    check("reset_outputs", {ack, uart_send, uart_data, busy, echo_level, echo_ovf}, 0);
    send_cyc.delete();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic wait_sends(input int n, input int limit);
    int k = 0;
    while (send_cyc.size() < n && k < limit) begin
      @(negedge sys_clk);
      k++;
    end
    check("wait_sends", 32'(send_cyc.size() >= n), 1);
  endtask

  task automatic drain();
    repeat (2 * BC) @(negedge sys_clk);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_data = 32'h4433_2211;

    // Single held requester: latency 1, spacing BC+1.
    do_reset();
    repeat (3) exp_q.push_back({4'b0001, 8'h11});
    t0  = cyc;
    req = 4'b0001;
    wait_sends(3, 4 * (BC + 1));
    req = '0;
    if (send_cyc.size() >= 3) begin
      check("grant_latency", send_cyc[0] - t0, 1);
      check("spacing_1", send_cyc[1] - send_cyc[0], BC + 1);
      check("spacing_2", send_cyc[2] - send_cyc[1], BC + 1);
    end
    drain();

    // All four requesting: round-robin from requester 0.
    do_reset();
    exp_q.push_back({4'b0001, 8'h11});
    exp_q.push_back({4'b0010, 8'h22});
    exp_q.push_back({4'b0100, 8'h33});
    exp_q.push_back({4'b1000, 8'h44});
    exp_q.push_back({4'b0001, 8'h11});
    req = 4'b1111;
    wait_sends(5, 6 * (BC + 1));
    req = '0;
    if (send_cyc.size() >= 5) check("rr_spacing", send_cyc[4] - send_cyc[3], BC + 1);
    drain();

    // Reset in the middle of a GAP.
    do_reset();
    exp_q.push_back({4'b0001, 8'h11});
    req = 4'b0001;
    wait_sends(1, 2 * (BC + 1));
    repeat (BC / 2) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    req       = 4'b0100;
    #1;
    check("midgap_reset_data", uart_data, 0);
    check("midgap_reset_busy", busy, 0);
    check("midgap_reset_ctl", {ack, uart_send}, 0);
    repeat (3) @(negedge sys_clk);
    send_cyc.delete();
    exp_q.push_back({4'b0100, 8'h33});
    t0        = cyc;
    sys_rst_n = 1'b1;
    wait_sends(1, 2 * (BC + 1));
    req = '0;
    if (send_cyc.size() >= 1) check("post_reset_latency", send_cyc[0] - t0, 1);
    drain();

`ifdef UART_TX_ARB_ECHO_EN
    // Echo bytes take priority over a held requester and carry no ack.
    do_reset();
    exp_q.push_back({4'b0000, 8'hA1});
    exp_q.push_back({4'b0000, 8'hA2});
    exp_q.push_back({4'b0000, 8'hA3});
    exp_q.push_back({4'b0010, 8'h22});
    t0       = cyc;
    rx_valid = 1'b1;
    rx_data  = 8'hA1;
    @(negedge sys_clk);
    rx_data  = 8'hA2;
    req      = 4'b0010;
    @(negedge sys_clk);
    rx_data  = 8'hA3;
    @(negedge sys_clk);
    rx_valid = 1'b0;
    wait_sends(4, 5 * (BC + 1));
    req = '0;
    if (send_cyc.size() >= 1) check("echo_latency", send_cyc[0] - t0, 2);
    drain();
    check("echo_level_empty", echo_level, 0);

    // Six bytes during a GAP: four kept, overflow flagged.
    do_reset();
    exp_q.push_back({4'b0001, 8'h11});
    req = 4'b0001;
    wait_sends(1, 2 * (BC + 1));
    req = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b0000, 8'hB1 + 8'(i)});
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'hB1 + 8'(i);
      @(negedge sys_clk);
    end
    rx_valid = 1'b0;
    check("ovf_level", echo_level, 4);
    check("ovf_flag", echo_ovf, 1);
    wait_sends(5, 6 * (BC + 1));
    drain();
    check("ovf_drained_level", echo_level, 0);
    check("ovf_sticky", echo_ovf, 1);
`else
    // Echo disabled: received bytes are ignored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h5A + 8'(i);
      @(negedge sys_clk);
      rx_valid = 1'b0;
      @(negedge sys_clk);
      check("noecho_level", echo_level, 0);
    end
    repeat (2 * BC) @(negedge sys_clk);
    check("noecho_no_send", send_cyc.size(), 0);
    check("noecho_ovf", echo_ovf, 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_hs` transmitter between four requesters (key-driven command sources) and an optional receive-echo path. It grants one byte per transmit slot, pulses `uart_send` with the granted byte, and spaces consecutive sends so the next byte never overruns the transmitter. It sits between the key/command logic and `uart_hs`, replacing ad-hoc priority chains in the top level.

## Interface
- `BYTE_CYCLES`, 4340, sys_clk cycles reserved per transmitted byte (50 MHz, 115200 baud, 10 bits); legal range 2..65535
- `sys_clk`  in  1  clock
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `req`  in  4  level request per requester; held until acked
- `req_data`  in  32  byte for requester i on bits [8i+7:8i]
- `ack`  out  4  one-hot, 1-cycle pulse when requester i is granted
- `rx_valid`  in  1  1-cycle pulse, received byte available (from `uart_hs` `uart_rec`)
- `rx_data`  in  8  received byte
- `uart_send`  out  1  1-cycle send strobe to `uart_hs`
- `uart_data`  out  8  byte to `uart_hs`, valid while `uart_send`=1, held afterwards
- `busy`  out  1  high while a transmit slot is in progress
- `echo_level`  out  3  echo FIFO occupancy, 0..4
- `echo_ovf`  out  1  sticky: an echo byte was dropped

## Operation
- The state machine has two states: IDLE and GAP.
- **IDLE:**
  - If the echo FIFO is non-empty, the echo byte wins: it is popped, `uart_send` and `uart_data` are registered, and `ack` stays 0.
  - Otherwise, if any `req` is set, a round-robin grant is made. The search starts at `last+1` mod 4. The winner gets `ack[w]`=1 and `uart_data`=`req_data[w]`, and `last` is set to w.
  - On any grant: `uart_send`=1, `cnt`=`BYTE_CYCLES-1`, next state is GAP.
  - With no demand, the block stays in IDLE.
- **GAP:**
  - `uart_send`=0 and `ack`=0.
  - `cnt` decrements each cycle.
  - When `cnt`==0, next state is IDLE.
- **Round-robin pointer:** `last` resets to 3, so requester 0 is served first after reset. The pointer advances only on requester grants, not on echo grants.
- **Requester handshake:** a requester that keeps `req` high after `ack` is re-queued. A continuously held key therefore produces repeated sends, shared fairly with the other requesters.
- **Echo FIFO:** 4 entries, 8 bits, first-in first-out.
  - `rx_valid` while not full: push.
  - `rx_valid` while full with no pop in the same cycle: the byte is dropped and `echo_ovf` is set. `echo_ovf` clears only on reset.
  - Push and pop in the same cycle: both are performed and occupancy is unchanged. This applies when full too, with no overflow.
  - Pop on empty never occurs.
- **`busy`** = (state == GAP).
- **Reset values:** `uart_send`=0, `uart_data`=0, `ack`=0, `busy`=0, `echo_level`=0, `echo_ovf`=0, state IDLE, `cnt`=0, FIFO pointers 0.
- **Reset mid-slot:** the slot is abandoned immediately. No further `uart_send` is issued until after reset is released.

## Timing
- **Grant latency:** `req` or FIFO non-empty sampled in IDLE produces `uart_send`/`ack` one clock later.
- **Send spacing:** under continuous demand, `uart_send` pulses are exactly `BYTE_CYCLES+1` cycles apart.
- **Echo latency:** `rx_valid` at cycle t, with the block idle and the FIFO empty, gives the FIFO non-empty at t+1 and `uart_send` with that byte at t+2.
- **Echo order:** echo bytes leave in arrival order.
- **No combinational paths** from inputs to outputs.

## Configuration
- Macro: `UART_TX_ARB_ECHO_EN`.
- **Defined:** the echo FIFO and echo priority exist as described above.
- **Undefined:**
  - No FIFO is instantiated and `rx_valid`/`rx_data` are ignored.
  - `echo_level` is tied to 0 and `echo_ovf` is tied to 0.
  - Arbitration is pure round-robin over `req`.

## Structure
- **Package `uart_arb_pkg`:** state enum (IDLE, GAP), `NREQ`=4, `ECHO_DEPTH`=4, `ECHO_PTR_W`=2.
- **Sub-module `uart_echo_fifo`:** 4×8 synchronous FIFO with push/pop/full/empty/level/ovf. It is instantiated only under `UART_TX_ARB_ECHO_EN`.

## Test plan
1. Reset, then `req`=4'b0001 with byte 0x11 held → first `uart_send` with `uart_data`=0x11 and `ack`=4'b0001 at 1 cycle. Repeats every `BYTE_CYCLES+1` cycles.
2. `req`=4'b1111 held, bytes 0x11/0x22/0x33/0x44 → send order 0x11, 0x22, 0x33, 0x44, 0x11, each acked once per round.
3. Echo build, three `rx_valid` pulses 0xA1, 0xA2, 0xA3 while `req`=4'b0010 is held → 0xA1, 0xA2, 0xA3 are sent before 0x22, with `ack`=0 on echo sends.
4. Echo build, six back-to-back `rx_valid` pulses while in GAP → `echo_level`=4, `echo_ovf`=1, and only the first four bytes are later sent.
5. Assert `sys_rst_n`=0 halfway through GAP → all outputs 0 immediately. Holding `req`=4'b0100 afterwards gives the next send 1 cycle after reset release, with byte 0x33.
6. Non-echo build, `rx_valid` pulses with `req`=0 → no `uart_send`, and `echo_level`=0.
